// File: rtl/led_matrix_scanner_pkg.sv
// Shared definitions for the LED matrix scanner: default geometry, FSM state
// encoding and the brightness code that forces the PWM fully on.
package led_matrix_scanner_pkg;

  localparam int ROWS_DEF = 6;
  localparam int COLS_DEF = 6;

  localparam logic [3:0] BRI_FULL = 4'd15;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// User-side bus of the scanner: back-buffer row writes, frame swap handshake,
// global brightness and the frame-boundary strobe.
interface led_matrix_scanner_if
  import led_matrix_scanner_pkg::*;
#(
  parameter int COLS = COLS_DEF
);

  logic            wr_en;
  logic [2:0]      wr_row;
  logic [COLS-1:0] wr_data;
  logic            swap_req;
  logic            swap_ack;
  logic [3:0]      brightness;
  logic            frame_done;

  modport master (
    output wr_en, wr_row, wr_data, swap_req, brightness,
    input  swap_ack, frame_done
  );

  modport slave (
    input  wr_en, wr_row, wr_data, swap_req, brightness,
    output swap_ack, frame_done
  );

endinterface

// File: rtl/led_matrix_scanner_fb.sv
// Double-buffered frame store. User writes always land in the back bank; the
// scanner reads the front bank one row at a time. A flip swaps the roles.
module led_matrix_fb
  import led_matrix_scanner_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int RIDX_W = $clog2(ROWS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [2:0]        i_wr_row,
  input  logic [COLS-1:0]   i_wr_data,
  input  logic              i_flip,
  input  logic [RIDX_W-1:0] i_rd_row,
  output logic [COLS-1:0]   o_rd_data
);

  logic [COLS-1:0] r_bank [2][ROWS];
  logic            r_front;
  logic            w_wr_ok;

  // Out-of-range row indices are dropped rather than aliased onto a real row.
  assign w_wr_ok   = i_wr_en && (32'(i_wr_row) < 32'(ROWS));
  assign o_rd_data = r_bank[r_front][i_rd_row];

  // Bank storage and front-bank select; a write in the flip cycle still uses
  // the pre-flip back bank, so it becomes visible in the new front.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_front <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          r_bank[b][r] <= '0;
        end
      end
    end else begin
      if (w_wr_ok) begin
        r_bank[~r_front][i_wr_row] <= i_wr_data;
      end
      if (i_flip) begin
        r_front <= ~r_front;
      end
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scan refresh controller for the LED matrix: alternates a blanking gap and
// a row drive window, applies global PWM brightness, and exchanges frame
// buffers on request at frame boundaries.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_BLANK | all LEDs off for BLANK_CYCLES before the current row
//   ST_DRIVE | row_idx driven for ROW_CYCLES, columns gated by PWM
module led_matrix_scanner
  import led_matrix_scanner_pkg::*;
#(
  parameter int ROWS         = ROWS_DEF,
  parameter int COLS         = COLS_DEF,
  parameter int ROW_CYCLES   = 2000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  led_matrix_scanner_if.slave  bus,
  output logic [ROWS-1:0]      o_row,
  output logic [COLS-1:0]      o_col
);

  localparam int CNT_W  = $clog2(max2(ROW_CYCLES, BLANK_CYCLES));
  localparam int RIDX_W = $clog2(ROWS);

  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DRIVE_LAST = CNT_W'(ROW_CYCLES - 1);
  localparam logic [RIDX_W-1:0] ROW_LAST   = RIDX_W'(ROWS - 1);

  scan_state_e       r_state;
  scan_state_e       w_state_nxt;
  logic [CNT_W-1:0]  r_dwell;
  logic [CNT_W-1:0]  w_dwell_nxt;
  logic [RIDX_W-1:0] r_row_idx;
  logic [RIDX_W-1:0] w_row_idx_nxt;
  logic              w_boundary;
  logic              w_drive_start;

  logic [3:0]        r_pwm_cnt;
  logic [3:0]        r_bri_q;
  logic              w_lit;

  logic              w_flip;
  logic [COLS-1:0]   w_front_row;
  logic [ROWS-1:0]   w_row_onehot;

  logic [ROWS-1:0]   r_row;
  logic [COLS-1:0]   r_col;
  logic              r_frame_done;
  logic              r_swap_ack;

  assign w_drive_start = (r_state == ST_BLANK) && (w_state_nxt == ST_DRIVE);
  assign w_flip        = w_boundary && bus.swap_req;
  assign w_lit         = (r_bri_q == BRI_FULL) || (r_pwm_cnt < r_bri_q);
  assign w_row_onehot  = ROWS'(1) << r_row_idx;

  led_matrix_fb #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .RIDX_W (RIDX_W)
  ) u_fb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (bus.wr_en),
    .i_wr_row  (bus.wr_row),
    .i_wr_data (bus.wr_data),
    .i_flip    (w_flip),
    .i_rd_row  (r_row_idx),
    .o_rd_data (w_front_row)
  );

  // Scan state, phase dwell counter and current row index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_BLANK;
      r_dwell   <= '0;
      r_row_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dwell   <= w_dwell_nxt;
      r_row_idx <= w_row_idx_nxt;
    end
  end

  // Phase sequencing; the last DRIVE cycle of the last row is the frame boundary.
  always_comb begin
    w_state_nxt   = r_state;
    w_dwell_nxt   = r_dwell + CNT_W'(1);
    w_row_idx_nxt = r_row_idx;
    w_boundary    = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_dwell == BLANK_LAST) begin
          w_state_nxt = ST_DRIVE;
          w_dwell_nxt = '0;
        end
      end
      ST_DRIVE: begin
        if (r_dwell == DRIVE_LAST) begin
          w_state_nxt = ST_BLANK;
          w_dwell_nxt = '0;
          if (r_row_idx == ROW_LAST) begin
            w_row_idx_nxt = '0;
            w_boundary    = 1'b1;
          end else begin
            w_row_idx_nxt = r_row_idx + RIDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_dwell_nxt = '0;
      end
    endcase
  end

  // PWM phase restarts and brightness is latched at each row start, so a
  // brightness change never splits a row.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm_cnt <= '0;
      r_bri_q   <= '0;
    end else if (w_drive_start) begin
      r_pwm_cnt <= '0;
      r_bri_q   <= bus.brightness;
    end else if (r_state == ST_DRIVE) begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
    end
  end

  // Registered pin drive: one cycle behind the scan state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row <= '0;
      r_col <= '1;
    end else if (r_state == ST_DRIVE) begin
      r_row <= w_row_onehot;
      r_col <= ~(w_front_row & {COLS{w_lit}});
    end else begin
      r_row <= '0;
      r_col <= '1;
    end
  end

  // Frame-boundary and swap-acknowledge strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_done <= 1'b0;
      r_swap_ack   <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      r_swap_ack   <= w_flip;
    end
  end

  assign o_row          = r_row;
  assign o_col          = r_col;
  assign bus.frame_done = r_frame_done;
  assign bus.swap_ack   = r_swap_ack;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for the LED matrix scanner with a 20-cycle row drive and a
// 2-cycle blank (132-cycle frame). Frames are captured sample by sample and
// compared against a small timing/PWM model.
module tb_led_matrix_scanner;

  localparam int FRAME = 132;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] row;
  logic [5:0] col;

  int total = 0;
  int bad   = 0;

  logic [5:0] cap_row [FRAME];
  logic [5:0] cap_col [FRAME];
  logic       cap_fd  [FRAME];
  logic       cap_ack [FRAME];

  always #5 clk = ~clk;

  led_matrix_scanner_if #(.COLS(6)) bus ();

  led_matrix_scanner #(
    .ROWS         (6),
    .COLS         (6),
    .ROW_CYCLES   (20),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus),
    .o_row (row),
    .o_col (col)
  );

  // Offset o counts samples after a frame boundary (or reset) edge.
  // Row r is visible on samples 22r+3 .. 22r+22.
  function automatic logic [5:0] exp_row(input int o);
    int q;
    q = o - 3;
    if (q < 0 || (q % 22) >= 20) return 6'h00;
    return 6'b000001 << (q / 22);
  endfunction

  function automatic logic [5:0] exp_col(input int o, input logic [35:0] pat, input int bri);
    int   q;
    int   p;
    logic lit;
    q = o - 3;
    if (q < 0 || (q % 22) >= 20) return 6'h3F;
    p   = (q % 22) % 16;
    lit = (bri == 15) || (p < bri);
    return ~(pat[(q / 22) * 6 +: 6] & {6{lit}});
  endfunction

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_row[i] = row;
      cap_col[i] = col;
      cap_fd[i]  = bus.frame_done;
      cap_ack[i] = bus.swap_ack;
    end
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_done !== 1'b1 && n < 300);
  endtask

  task automatic test_reset;
    logic [35:0] pat;
    pat = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (row !== 6'h00 || col !== 6'h3F || bus.swap_ack !== 1'b0 || bus.frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state row=%b col=%b ack=%b fd=%b want 000000 111111 0 0",
               row, col, bus.swap_ack, bus.frame_done);
    end
    rst = 1'b0;
    capture(FRAME);
    for (int i = 0; i < FRAME; i++) begin
      total++;
      if (cap_row[i] !== exp_row(i+1) || cap_col[i] !== exp_col(i+1, pat, 0) ||
          cap_fd[i] !== (i == FRAME-1) || cap_ack[i] !== 1'b0) begin
        bad++;
        $display("FAIL first_frame off=%0d row=%b col=%b fd=%b ack=%b want row=%b col=%b fd=%b ack=0",
                 i+1, cap_row[i], cap_col[i], cap_fd[i], cap_ack[i],
                 exp_row(i+1), exp_col(i+1, pat, 0), (i == FRAME-1));
      end
    end
  endtask

  task automatic test_swap_display;
    logic [35:0] pat;
    int n;
    pat = {30'h0, 6'b000101};
    bus.brightness = 4'd15;
    bus.wr_en = 1'b1; bus.wr_row = 3'd0; bus.wr_data = 6'b000101;
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_fd(n);
    total++;
    if (bus.frame_done !== 1'b1 || bus.swap_ack !== 1'b1) begin
      bad++;
      $display("FAIL swap_ack fd=%b ack=%b after %0d cycles want fd=1 ack=1", bus.frame_done, bus.swap_ack, n);
    end
    bus.swap_req = 1'b0;
    capture(FRAME);
    for (int i = 0; i < FRAME; i++) begin
      total++;
      if (cap_row[i] !== exp_row(i+1) || cap_col[i] !== exp_col(i+1, pat, 15) ||
          cap_fd[i] !== (i == FRAME-1) || cap_ack[i] !== 1'b0) begin
        bad++;
        $display("FAIL swap_frame off=%0d row=%b col=%b fd=%b ack=%b want row=%b col=%b fd=%b ack=0",
                 i+1, cap_row[i], cap_col[i], cap_fd[i], cap_ack[i],
                 exp_row(i+1), exp_col(i+1, pat, 15), (i == FRAME-1));
      end
    end
  endtask

  task automatic test_pwm;
    logic [35:0] pat;
    int n;
    pat = {6{6'h3F}};
    bus.brightness = 4'd4;
    for (int r = 0; r < 6; r++) begin
      bus.wr_en = 1'b1; bus.wr_row = 3'(r); bus.wr_data = 6'h3F;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    bus.swap_req = 1'b1;
    wait_fd(n);
    total++;
    if (bus.swap_ack !== 1'b1) begin
      bad++;
      $display("FAIL pwm_swap_ack ack=%b after %0d cycles want 1", bus.swap_ack, n);
    end
    bus.swap_req = 1'b0;
    capture(FRAME);
    for (int i = 0; i < FRAME; i++) begin
      total++;
      if (cap_row[i] !== exp_row(i+1) || cap_col[i] !== exp_col(i+1, pat, 4) ||
          cap_fd[i] !== (i == FRAME-1) || cap_ack[i] !== 1'b0) begin
        bad++;
        $display("FAIL pwm4_frame off=%0d row=%b col=%b fd=%b ack=%b want row=%b col=%b fd=%b ack=0",
                 i+1, cap_row[i], cap_col[i], cap_fd[i], cap_ack[i],
                 exp_row(i+1), exp_col(i+1, pat, 4), (i == FRAME-1));
      end
    end
    bus.brightness = 4'd0;
    capture(FRAME);
    for (int i = 0; i < FRAME; i++) begin
      total++;
      if (cap_row[i] !== exp_row(i+1) || cap_col[i] !== 6'h3F ||
          cap_fd[i] !== (i == FRAME-1) || cap_ack[i] !== 1'b0) begin
        bad++;
        $display("FAIL pwm0_frame off=%0d row=%b col=%b fd=%b ack=%b want row=%b col=111111 fd=%b ack=0",
                 i+1, cap_row[i], cap_col[i], cap_fd[i], cap_ack[i], exp_row(i+1), (i == FRAME-1));
      end
    end
  endtask

  task automatic test_bad_row;
    logic [35:0] pat;
    int n;
    bus.brightness = 4'd15;
    bus.wr_en = 1'b1; bus.wr_row = 3'd6; bus.wr_data = 6'h3F;
    @(negedge clk);
    bus.wr_row = 3'd7;
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_fd(n);
    total++;
    if (bus.frame_done !== 1'b1 || bus.swap_ack !== 1'b0) begin
      bad++;
      $display("FAIL bad_row_sync fd=%b ack=%b after %0d cycles want fd=1 ack=0", bus.frame_done, bus.swap_ack, n);
    end
    pat = {6{6'h3F}};
    capture(FRAME);
    for (int i = 0; i < FRAME; i++) begin
      total++;
      if (cap_row[i] !== exp_row(i+1) || cap_col[i] !== exp_col(i+1, pat, 15) ||
          cap_fd[i] !== (i == FRAME-1) || cap_ack[i] !== 1'b0) begin
        bad++;
        $display("FAIL bad_row_front off=%0d row=%b col=%b fd=%b ack=%b want row=%b col=%b fd=%b ack=0",
                 i+1, cap_row[i], cap_col[i], cap_fd[i], cap_ack[i],
                 exp_row(i+1), exp_col(i+1, pat, 15), (i == FRAME-1));
      end
    end
    bus.swap_req = 1'b1;
    wait_fd(n);
    total++;
    if (bus.swap_ack !== 1'b1) begin
      bad++;
      $display("FAIL bad_row_swap ack=%b after %0d cycles want 1", bus.swap_ack, n);
    end
    bus.swap_req = 1'b0;
    pat = {30'h0, 6'b000101};
    capture(FRAME);
    for (int i = 0; i < FRAME; i++) begin
      total++;
      if (cap_row[i] !== exp_row(i+1) || cap_col[i] !== exp_col(i+1, pat, 15) ||
          cap_fd[i] !== (i == FRAME-1) || cap_ack[i] !== 1'b0) begin
        bad++;
        $display("FAIL bad_row_back off=%0d row=%b col=%b fd=%b ack=%b want row=%b col=%b fd=%b ack=0",
                 i+1, cap_row[i], cap_col[i], cap_fd[i], cap_ack[i],
                 exp_row(i+1), exp_col(i+1, pat, 15), (i == FRAME-1));
      end
    end
  endtask

  task automatic test_no_swap;
    logic [35:0] pat;
    int n;
    bus.wr_en = 1'b1; bus.wr_row = 3'd2; bus.wr_data = 6'h0F;
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_fd(n);
    total++;
    if (bus.frame_done !== 1'b1 || bus.swap_ack !== 1'b0) begin
      bad++;
      $display("FAIL no_swap_sync fd=%b ack=%b after %0d cycles want fd=1 ack=0", bus.frame_done, bus.swap_ack, n);
    end
    pat = {30'h0, 6'b000101};
    for (int f = 0; f < 3; f++) begin
      capture(FRAME);
      for (int i = 0; i < FRAME; i++) begin
        total++;
        if (cap_row[i] !== exp_row(i+1) || cap_col[i] !== exp_col(i+1, pat, 15) ||
            cap_fd[i] !== (i == FRAME-1) || cap_ack[i] !== 1'b0) begin
          bad++;
          $display("FAIL no_swap_hold frame=%0d off=%0d row=%b col=%b fd=%b ack=%b want row=%b col=%b fd=%b ack=0",
                   f, i+1, cap_row[i], cap_col[i], cap_fd[i], cap_ack[i],
                   exp_row(i+1), exp_col(i+1, pat, 15), (i == FRAME-1));
        end
      end
    end
    capture(FRAME-1);
    bus.wr_en = 1'b1; bus.wr_row = 3'd1; bus.wr_data = 6'h21;
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    total++;
    if (bus.frame_done !== 1'b1 || bus.swap_ack !== 1'b1) begin
      bad++;
      $display("FAIL swap_cycle_ack fd=%b ack=%b want fd=1 ack=1", bus.frame_done, bus.swap_ack);
    end
    bus.swap_req = 1'b0;
    pat = {6'h3F, 6'h3F, 6'h3F, 6'h0F, 6'h21, 6'h3F};
    capture(FRAME);
    for (int i = 0; i < FRAME; i++) begin
      total++;
      if (cap_row[i] !== exp_row(i+1) || cap_col[i] !== exp_col(i+1, pat, 15) ||
          cap_fd[i] !== (i == FRAME-1) || cap_ack[i] !== 1'b0) begin
        bad++;
        $display("FAIL swap_cycle_write off=%0d row=%b col=%b fd=%b ack=%b want row=%b col=%b fd=%b ack=0",
                 i+1, cap_row[i], cap_col[i], cap_fd[i], cap_ack[i],
                 exp_row(i+1), exp_col(i+1, pat, 15), (i == FRAME-1));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [35:0] pat;
    int n;
    bus.swap_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_fd(n);
      total++;
      if (bus.frame_done !== 1'b1 || bus.swap_ack !== 1'b1) begin
        bad++;
        $display("FAIL held_req_ack k=%0d fd=%b ack=%b after %0d cycles want fd=1 ack=1",
                 k, bus.frame_done, bus.swap_ack, n);
      end
    end
    bus.swap_req = 1'b0;
    pat = {6'h3F, 6'h3F, 6'h3F, 6'h0F, 6'h21, 6'h3F};
    capture(FRAME);
    for (int i = 0; i < FRAME; i++) begin
      total++;
      if (cap_row[i] !== exp_row(i+1) || cap_col[i] !== exp_col(i+1, pat, 15) ||
          cap_fd[i] !== (i == FRAME-1) || cap_ack[i] !== 1'b0) begin
        bad++;
        $display("FAIL double_swap off=%0d row=%b col=%b fd=%b ack=%b want row=%b col=%b fd=%b ack=0",
                 i+1, cap_row[i], cap_col[i], cap_fd[i], cap_ack[i],
                 exp_row(i+1), exp_col(i+1, pat, 15), (i == FRAME-1));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [35:0] pat;
    int n;
    pat = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (row !== 6'b001000 && n < 300);
    total++;
    if (row !== 6'b001000) begin
      bad++;
      $display("FAIL find_row3 row=%b after %0d cycles want 001000", row, n);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (row !== 6'h00 || col !== 6'h3F || bus.swap_ack !== 1'b0 || bus.frame_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset row=%b col=%b ack=%b fd=%b want 000000 111111 0 0",
               row, col, bus.swap_ack, bus.frame_done);
    end
    rst = 1'b0;
    capture(FRAME);
    for (int i = 0; i < FRAME; i++) begin
      total++;
      if (cap_row[i] !== exp_row(i+1) || cap_col[i] !== exp_col(i+1, pat, 15) ||
          cap_fd[i] !== (i == FRAME-1) || cap_ack[i] !== 1'b0) begin
        bad++;
        $display("FAIL cleared_front off=%0d row=%b col=%b fd=%b ack=%b want row=%b col=%b fd=%b ack=0",
                 i+1, cap_row[i], cap_col[i], cap_fd[i], cap_ack[i],
                 exp_row(i+1), exp_col(i+1, pat, 15), (i == FRAME-1));
      end
    end
    bus.swap_req = 1'b1;
    wait_fd(n);
    total++;
    if (bus.swap_ack !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_swap ack=%b after %0d cycles want 1", bus.swap_ack, n);
    end
    bus.swap_req = 1'b0;
    capture(FRAME);
    for (int i = 0; i < FRAME; i++) begin
      total++;
      if (cap_row[i] !== exp_row(i+1) || cap_col[i] !== exp_col(i+1, pat, 15) ||
          cap_fd[i] !== (i == FRAME-1) || cap_ack[i] !== 1'b0) begin
        bad++;
        $display("FAIL cleared_back off=%0d row=%b col=%b fd=%b ack=%b want row=%b col=%b fd=%b ack=0",
                 i+1, cap_row[i], cap_col[i], cap_fd[i], cap_ack[i],
                 exp_row(i+1), exp_col(i+1, pat, 15), (i == FRAME-1));
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.wr_en      = 1'b0;
    bus.wr_row     = 3'd0;
    bus.wr_data    = 6'h00;
    bus.swap_req   = 1'b0;
    bus.brightness = 4'd0;
    test_reset;
    test_swap_display;
    test_pwm;
    test_bad_row;
    test_no_swap;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
